// File: rtl/clk_reset_sequencer.sv
// PLL lock supervisor and staged domain reset releaser.
// Runs on the free-running reference clock and holds every domain in reset until LOCK is stable.
module clk_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned LOCK_FILTER    = 1024,
  parameter int unsigned STAGGER        = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned PLL_RST_CYCLES = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   clear_status,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_ready,
  output logic                   lost_lock,
  output logic [7:0]             relock_count
);

  localparam int unsigned MaxA   = (LOCK_FILTER > STAGGER) ? LOCK_FILTER : STAGGER;
  localparam int unsigned MaxB   = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int unsigned MaxAll = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxAll) + 1;
  localparam int unsigned IdxW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] FilterLast  = CntW'(LOCK_FILTER - 1);
  localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StFilter,
    StRelease,
    StRun
  } stateT;

  stateT                   stateQ, stateD;
  logic [CntW-1:0]         cntQ, cntD;
  logic [IdxW-1:0]         idxQ, idxD;
  logic [1:0]              syncQ;
  logic                    lk;
  logic                    pllRstQ, pllRstD;
  logic [NUM_DOMAINS-1:0]  domainResetQ, domainResetD;
  logic                    allReadyQ, allReadyD;
  logic                    lostLockQ, lostLockD;
  logic [7:0]              relockQ, relockD;
  logic                    relockInc;
  logic                    lostSet;

  assign lk = syncQ[1];

  always_comb begin
    stateD       = stateQ;
    cntD         = cntQ + CntW'(1);
    idxD         = idxQ;
    domainResetD = domainResetQ;
    relockInc    = 1'b0;
    lostSet      = 1'b0;

    unique case (stateQ)
      StPllRst: begin
        if (cntQ == RstLast) begin
          stateD = StWaitLock;
          cntD   = '0;
        end
      end
      StWaitLock: begin
        if (lk) begin
          stateD = StFilter;
          cntD   = '0;
        end else if (cntQ == TimeoutLast) begin
          stateD    = StPllRst;
          cntD      = '0;
          relockInc = 1'b1;
        end
      end
      StFilter: begin
        if (!lk) begin
          stateD = StWaitLock;
          cntD   = '0;
        end else if (cntQ == FilterLast) begin
          stateD          = StRelease;
          cntD            = '0;
          idxD            = '0;
          domainResetD[0] = 1'b0;
        end
      end
      StRelease: begin
        if (!lk) begin
          stateD    = StPllRst;
          cntD      = '0;
          relockInc = 1'b1;
        end else if (idxQ == IdxLast) begin
          stateD       = StRun;
          cntD         = '0;
          domainResetD = '0;
        end else if (cntQ == StaggerLast) begin
          cntD = '0;
          idxD = idxQ + IdxW'(1);
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (idxD == IdxW'(k)) domainResetD[k] = 1'b0;
          end
        end
      end
      StRun: begin
        cntD = '0;
        if (!lk) begin
          stateD    = StPllRst;
          relockInc = 1'b1;
          lostSet   = 1'b1;
        end
      end
      default: begin
        stateD = StPllRst;
        cntD   = '0;
      end
    endcase

    // Domains stay fully in reset in every state before the release stagger.
    if (stateD == StPllRst || stateD == StWaitLock || stateD == StFilter) begin
      domainResetD = '1;
    end

    pllRstD   = (stateD == StPllRst);
    allReadyD = (stateD == StRun);

    // A set in the same cycle as a clear wins.
    if (lostSet) begin
      lostLockD = 1'b1;
    end else if (clear_status) begin
      lostLockD = 1'b0;
    end else begin
      lostLockD = lostLockQ;
    end

    relockD = (relockInc && relockQ != 8'hFF) ? relockQ + 8'd1 : relockQ;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ       <= StPllRst;
      cntQ         <= '0;
      idxQ         <= '0;
      syncQ        <= 2'b00;
      pllRstQ      <= 1'b1;
      domainResetQ <= '1;
      allReadyQ    <= 1'b0;
      lostLockQ    <= 1'b0;
      relockQ      <= 8'd0;
    end else begin
      stateQ       <= stateD;
      cntQ         <= cntD;
      idxQ         <= idxD;
      syncQ        <= {syncQ[0], pll_locked};
      pllRstQ      <= pllRstD;
      domainResetQ <= domainResetD;
      allReadyQ    <= allReadyD;
      lostLockQ    <= lostLockD;
      relockQ      <= relockD;
    end
  end

  assign pll_rst      = pllRstQ;
  assign domain_reset = domainResetQ;
  assign all_ready    = allReadyQ;
  assign lost_lock    = lostLockQ;
  assign relock_count = relockQ;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Scoreboard bench: stimulus pushes expected output-vector changes with their cycle numbers,
// a negedge monitor pops one entry per observed change and compares value and timing.
module tb_clk_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       clear_status;
  logic       pll_rst;
  logic [2:0] domain_reset;
  logic       all_ready;
  logic       lost_lock;
  logic [7:0] relock_count;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  int          expCyc[$];
  logic [13:0] expVal[$];
  string       expTag[$];

  clk_reset_sequencer #(
    .NUM_DOMAINS   (3),
    .LOCK_FILTER   (8),
    .STAGGER       (4),
    .LOCK_TIMEOUT  (32),
    .PLL_RST_CYCLES(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .clear_status(clear_status),
    .pll_rst     (pll_rst),
    .domain_reset(domain_reset),
    .all_ready   (all_ready),
    .lost_lock   (lost_lock),
    .relock_count(relock_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [13:0] vec(input logic pr, input logic [2:0] dr, input logic ar,
                                      input logic ll, input logic [7:0] rc);
    return {pr, dr, ar, ll, rc};
  endfunction

  task automatic push(input int c, input logic [13:0] v, input string tag);
    expCyc.push_back(c);
    expVal.push_back(v);
    expTag.push_back(tag);
  endtask

  task automatic waitAt(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Full lock-and-release sequence expected after reset release / relock at reference t.
  task automatic pushRelease(input int f, input logic ll, input logic [7:0] rc, input string tag);
    push(f,      vec(1'b0, 3'b110, 1'b0, ll, rc), {tag, "_bit0"});
    push(f + 4,  vec(1'b0, 3'b100, 1'b0, ll, rc), {tag, "_bit1"});
    push(f + 8,  vec(1'b0, 3'b000, 1'b0, ll, rc), {tag, "_bit2"});
    push(f + 9,  vec(1'b0, 3'b000, 1'b1, ll, rc), {tag, "_ready"});
  endtask

  // Monitor: every change of the output vector consumes one expectation.
  initial begin
    logic [13:0] prev;
    logic [13:0] cur;
    int          ec;
    logic [13:0] ev;
    string       et;
    prev = '0;
    forever begin
      @(negedge clock);
      cur = {pll_rst, domain_reset, all_ready, lost_lock, relock_count};
      if (cur !== prev) begin
        compared++;
        if (expVal.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_change cyc=%0d actual=%h required=no change", cyc, cur);
        end else begin
          ec = expCyc.pop_front();
          ev = expVal.pop_front();
          et = expTag.pop_front();
          if (cur !== ev || (ec >= 0 && ec != cyc)) begin
            mismatched++;
            $display("FAIL %s actual=%h@cyc%0d required=%h@cyc%0d", et, cur, cyc, ev, ec);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int t0, t1, t3, t4, t5, t6, t7, t8;
    logic [7:0] rc;
    reset        = 1'b0;
    pll_locked   = 1'b0;
    clear_status = 1'b0;
    push(-1, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd0), "reset_state");
    #2 reset = 1'b1;

    // Clean start with lock held high.
    waitAt(3);
    t0 = cyc;
    reset      = 1'b0;
    pll_locked = 1'b1;
    push(t0 + 4, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd0), "t1_pllrst_end");
    pushRelease(t0 + 13, 1'b0, 8'd0, "t1");

    // Lock loss in RUN, then relock.
    t1 = t0 + 25;
    waitAt(t1);
    pll_locked = 1'b0;
    push(t1 + 3, vec(1'b1, 3'b111, 1'b0, 1'b1, 8'd1), "t4_loss");
    push(t1 + 7, vec(1'b0, 3'b111, 1'b0, 1'b1, 8'd1), "t4_pllrst_end");
    waitAt(t1 + 10);
    pll_locked = 1'b1;
    pushRelease(t1 + 21, 1'b1, 8'd1, "t4_relock");

    // clear_status in RUN.
    t3 = t1 + 32;
    waitAt(t3);
    clear_status = 1'b1;
    push(t3 + 1, vec(1'b0, 3'b000, 1'b1, 1'b0, 8'd1), "t5_clear_run");
    waitAt(t3 + 1);
    clear_status = 1'b0;

    // Loss in RUN, clear during PLLRST, then loss during RELEASE.
    t4 = t3 + 3;
    waitAt(t4);
    pll_locked = 1'b0;
    push(t4 + 3, vec(1'b1, 3'b111, 1'b0, 1'b1, 8'd2), "t5_loss_run");
    waitAt(t4 + 4);
    clear_status = 1'b1;
    push(t4 + 5, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd2), "t5_clear_pllrst");
    waitAt(t4 + 5);
    clear_status = 1'b0;
    push(t4 + 7, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd2), "t5_pllrst_end");
    waitAt(t4 + 8);
    pll_locked = 1'b1;
    push(t4 + 19, vec(1'b0, 3'b110, 1'b0, 1'b0, 8'd2), "t5_bit0");
    waitAt(t4 + 20);
    pll_locked = 1'b0;
    push(t4 + 23, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd3), "t5_loss_release");
    push(t4 + 27, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd3), "t5_pllrst_end2");

    // One-cycle glitch after five high cycles must restart the filter.
    t5 = t4 + 30;
    waitAt(t5);
    pll_locked = 1'b1;
    waitAt(t5 + 5);
    pll_locked = 1'b0;
    waitAt(t5 + 6);
    pll_locked = 1'b1;
    push(t5 + 17, vec(1'b0, 3'b110, 1'b0, 1'b0, 8'd3), "t3_bit0");
    push(t5 + 21, vec(1'b0, 3'b100, 1'b0, 1'b0, 8'd3), "t3_bit1");

    // Async reset mid-RELEASE, then full restart.
    waitAt(t5 + 22);
    push(t5 + 22, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd0), "t6_async_reset");
    reset = 1'b1;
    t6 = t5 + 24;
    waitAt(t6);
    reset = 1'b0;
    push(t6 + 4, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd0), "t6_pllrst_end");
    pushRelease(t6 + 13, 1'b0, 8'd0, "t6");

    // No lock ever: periodic PLL pulses and saturating relock count.
    t7 = t6 + 24;
    waitAt(t7);
    push(t7, vec(1'b1, 3'b111, 1'b0, 1'b0, 8'd0), "t2_reset");
    reset      = 1'b1;
    pll_locked = 1'b0;
    t8 = t7 + 2;
    waitAt(t8);
    reset = 1'b0;
    push(t8 + 4, vec(1'b0, 3'b111, 1'b0, 1'b0, 8'd0), "t2_first_fall");
    for (int n = 1; n <= 258; n++) begin
      rc = (n > 255) ? 8'd255 : 8'(n);
      push(t8 + 36 * n,     vec(1'b1, 3'b111, 1'b0, 1'b0, rc), "t2_timeout_rise");
      push(t8 + 36 * n + 4, vec(1'b0, 3'b111, 1'b0, 1'b0, rc), "t2_timeout_fall");
    end
    waitAt(t8 + 36 * 258 + 10);

    while (expVal.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s actual=no change required=%h@cyc%0d", expTag[0], expVal[0], expCyc[0]);
      void'(expCyc.pop_front());
      void'(expVal.pop_front());
      void'(expTag.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
